// File: rtl/logic_gate_unit_pipe.sv
// logic_gate_unit_pipe: single-register bitwise gate stage with valid/ready
// handshake, chain mode (previous result reused as operand A) and registered
// AND/OR/XOR reduction flags.
// Optional accepted-beat counter is built only when LGU_BEAT_CNT_EN is defined;
// otherwise beat_cnt_out is tied to zero.
module logic_gate_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [2:0]       op_in,
  input  logic             chain_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             red_and_out,
  output logic             red_or_out,
  output logic             red_xor_out,
  output logic [CNT_W-1:0] beat_cnt_out
);

  // Parity of a result word.
  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Registered state. The accumulator is the same value as the result register:
  // both load only on accept and both clear on reset, so one register serves both.
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             red_and_q, red_and_d;
  logic             red_or_q, red_or_d;
  logic             red_xor_q, red_xor_d;

  logic             accept_s;
  logic [WIDTH-1:0] a_eff_s;
  logic [WIDTH-1:0] gate_s;

  // Ready whenever the output slot is empty or being drained; never in reset.
  assign in_ready_out = rst_n_in & (~valid_q | out_ready_in);
  assign accept_s     = in_valid_in & in_ready_out;
  assign a_eff_s      = chain_in ? result_q : a_in;

  // Gate function selected by opcode.
  always_comb begin
    gate_s = {WIDTH{1'b0}};
    case (op_in)
      3'd0:    gate_s = ~a_eff_s;
      3'd1:    gate_s = a_eff_s;
      3'd2:    gate_s = a_eff_s & b_in;
      3'd3:    gate_s = a_eff_s | b_in;
      3'd4:    gate_s = ~(a_eff_s & b_in);
      3'd5:    gate_s = ~(a_eff_s | b_in);
      3'd6:    gate_s = a_eff_s ^ b_in;
      3'd7:    gate_s = ~(a_eff_s ^ b_in);
      default: gate_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state for the output stage: load on accept, clear valid on drain, else hold.
  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    red_and_d = red_and_q;
    red_or_d  = red_or_q;
    red_xor_d = red_xor_q;
    if (accept_s) begin
      valid_d   = 1'b1;
      result_d  = gate_s;
      red_and_d = &gate_s;
      red_or_d  = |gate_s;
      red_xor_d = parity_f(gate_s);
    end else if (out_ready_in) begin
      valid_d   = 1'b0;
    end else begin
      valid_d   = valid_q;
    end
  end

  // Output stage registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      valid_q   <= 1'b0;
      result_q  <= {WIDTH{1'b0}};
      red_and_q <= 1'b0;
      red_or_q  <= 1'b0;
      red_xor_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      red_and_q <= red_and_d;
      red_or_q  <= red_or_d;
      red_xor_q <= red_xor_d;
    end
  end

  assign out_valid_out = valid_q;
  assign result_out    = result_q;
  assign red_and_out   = red_and_q;
  assign red_or_out    = red_or_q;
  assign red_xor_out   = red_xor_q;

`ifdef LGU_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Beat counter next-state: count accepts, wrap naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt_out = cnt_q;
`else
  assign beat_cnt_out = {CNT_W{1'b0}};
`endif

endmodule
